// File: rtl/hsem_regfile.sv
// Hardware semaphore register file: NSEM FREE/LOCKED semaphores with owner IDs,
// keyed clear-all, W1C unlock status with maskable level interrupt, and a saturating reject counter.
module hsem_regfile #(
    parameter int NSEM           = 8,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [7:0]                reg_addr,
    input  logic [AHB_DATA_WIDTH-1:0] ihwdata,
    output logic [AHB_DATA_WIDTH-1:0] ihrdata,
    output logic                      hsem_irq
);

    localparam logic [0:0] ST_FREE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [5:0] IDX_CR      = 6'h10;
    localparam logic [5:0] IDX_IER     = 6'h11;
    localparam logic [5:0] IDX_ISR     = 6'h12;
    localparam logic [5:0] IDX_MISR    = 6'h13;
    localparam logic [5:0] IDX_KEYR    = 6'h14;
    localparam logic [5:0] IDX_FAILCNT = 6'h15;

    logic [0:0]      sem_state_q [NSEM];
    logic [0:0]      sem_state_d [NSEM];
    logic [15:0]     sem_id_q    [NSEM];
    logic [15:0]     sem_id_d    [NSEM];
    logic [NSEM-1:0] ier_q, ier_d;
    logic [NSEM-1:0] isr_q, isr_d;
    logic [NSEM-1:0] isr_set, isr_clr;
    logic [15:0]     key_q, key_d;
    logic [15:0]     failcnt_q, failcnt_d;
    logic            irq_q;
    logic            fail_inc;
    logic            cr_key_ok;
    logic            sem_hit;
    logic [5:0]      idx;
    logic [31:0]     rdata;

    assign idx       = reg_addr[7:2];
    assign cr_key_ok = wr_en && (idx == IDX_CR) && (ihwdata[31:16] == key_q);

    always_comb begin
        fail_inc  = 1'b0;
        isr_set   = '0;
        isr_clr   = '0;
        sem_hit   = 1'b0;
        ier_d     = ier_q;
        key_d     = key_q;
        failcnt_d = failcnt_q;
        for (int n = 0; n < NSEM; n++) begin
            sem_state_d[n] = sem_state_q[n];
            sem_id_d[n]    = sem_id_q[n];
            sem_hit        = wr_en && (idx == n[5:0]);
            case (sem_state_q[n])
                ST_FREE: begin
                    if (sem_hit && ihwdata[31]) begin
                        sem_state_d[n] = ST_LOCKED;
                        sem_id_d[n]    = ihwdata[15:0];
                    end
                end
                ST_LOCKED: begin
                    // A foreign lock attempt is counted; a foreign unlock is silently dropped.
                    if (sem_hit && ihwdata[31]) begin
                        if (ihwdata[15:0] != sem_id_q[n]) fail_inc = 1'b1;
                    end else if ((sem_hit && ihwdata[15:0] == sem_id_q[n]) ||
                                 (cr_key_ok && sem_id_q[n][7:0] == ihwdata[7:0])) begin
                        sem_state_d[n] = ST_FREE;
                        sem_id_d[n]    = '0;
                        isr_set[n]     = 1'b1;
                    end
                end
                default: sem_state_d[n] = ST_FREE;
            endcase
        end
        if (wr_en) begin
            case (idx)
                IDX_IER:     ier_d     = ihwdata[NSEM-1:0];
                IDX_ISR:     isr_clr   = ihwdata[NSEM-1:0];
                IDX_KEYR:    key_d     = ihwdata[31:16];
                IDX_FAILCNT: failcnt_d = '0;
                default:     ;
            endcase
        end
        if (fail_inc && failcnt_q != 16'hFFFF) failcnt_d = failcnt_q + 16'd1;
        // Set is applied after clear so a same-edge release is never lost.
        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int n = 0; n < NSEM; n++) begin
                sem_state_q[n] <= ST_FREE;
                sem_id_q[n]    <= '0;
            end
            ier_q     <= '0;
            isr_q     <= '0;
            key_q     <= '0;
            failcnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int n = 0; n < NSEM; n++) begin
                sem_state_q[n] <= sem_state_d[n];
                sem_id_q[n]    <= sem_id_d[n];
            end
            ier_q     <= ier_d;
            isr_q     <= isr_d;
            key_q     <= key_d;
            failcnt_q <= failcnt_d;
            irq_q     <= |(isr_d & ier_d);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            for (int n = 0; n < NSEM; n++) begin
                if (idx == n[5:0]) rdata = {sem_state_q[n], 15'b0, sem_id_q[n]};
            end
            case (idx)
                IDX_IER:     rdata = 32'(ier_q);
                IDX_ISR:     rdata = 32'(isr_q);
                IDX_MISR:    rdata = 32'(isr_q & ier_q);
                IDX_KEYR:    rdata = {key_q, 16'h0000};
                IDX_FAILCNT: rdata = {16'h0000, failcnt_q};
                default:     ;
            endcase
        end
    end

    assign ihrdata  = AHB_DATA_WIDTH'(rdata);
    assign hsem_irq = irq_q;

endmodule

// File: tb/tb_hsem_regfile.sv
// Scoreboarded bench for hsem_regfile: directed scenarios plus random traffic against
// an array-based semaphore model; a negedge monitor checks every read cycle.
module tb_hsem_regfile;

    localparam int NSEM = 8;

    logic        hclk;
    logic        hresetn;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  reg_addr;
    logic [31:0] ihwdata;
    logic [31:0] ihrdata;
    logic        hsem_irq;

    hsem_regfile #(.NSEM(NSEM), .AHB_DATA_WIDTH(32)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .reg_addr (reg_addr),
        .ihwdata  (ihwdata),
        .ihrdata  (ihrdata),
        .hsem_irq (hsem_irq)
    );

    // clock / reset
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Behavioural model: per-semaphore owner table and plain integer registers.
    bit          m_locked [16];
    logic [15:0] m_id     [16];
    int          m_ier, m_isr, m_fail;
    logic [15:0] m_key;

    // Scoreboard entry: {addr[7:0], irq, data[31:0]}
    logic [40:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_locked[i] = 1'b0;
            m_id[i]     = 16'h0;
        end
        m_ier  = 0;
        m_isr  = 0;
        m_fail = 0;
        m_key  = 16'h0;
    endfunction

    function automatic logic model_irq();
        return (m_isr & m_ier) != 0;
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
        int i;
        i = int'(a[7:2]);
        if (i < NSEM) begin
            if (!m_locked[i]) begin
                if (d[31]) begin
                    m_locked[i] = 1'b1;
                    m_id[i]     = d[15:0];
                end
            end else if (d[31]) begin
                if (d[15:0] != m_id[i] && m_fail < 65535) m_fail++;
            end else if (d[15:0] == m_id[i]) begin
                m_locked[i] = 1'b0;
                m_id[i]     = 16'h0;
                m_isr       = m_isr | (1 << i);
            end
        end else begin
            case (i)
                16: if (d[31:16] == m_key) begin
                        for (int s = 0; s < NSEM; s++) begin
                            if (m_locked[s] && m_id[s][7:0] == d[7:0]) begin
                                m_locked[s] = 1'b0;
                                m_id[s]     = 16'h0;
                                m_isr       = m_isr | (1 << s);
                            end
                        end
                    end
                17: m_ier  = int'(d) & ((1 << NSEM) - 1);
                18: m_isr  = m_isr & ~int'(d);
                20: m_key  = d[31:16];
                21: m_fail = 0;
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int i;
        i = int'(a[7:2]);
        if (i < NSEM) return {m_locked[i], 15'b0, m_id[i]};
        case (i)
            17: return 32'(m_ier);
            18: return 32'(m_isr);
            19: return 32'(m_isr & m_ier);
            20: return {m_key, 16'h0};
            21: return 32'(m_fail);
            default: return 32'h0;
        endcase
    endfunction

    // driver tasks: inputs change 1 unit after the rising edge
    task automatic cycle_op(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
        @(posedge hclk);
        #1;
        wr_en    = w;
        rd_en    = r;
        reg_addr = a;
        ihwdata  = d;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle_op(1'b1, 1'b0, a, d);
        model_write(a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cycle_op(1'b0, 1'b1, a, 32'h0);
        exp_q.push_back({a, model_irq(), model_read(a)});
    endtask

    // read with a hand-derived expected value, independent of the model
    task automatic rd_k(input logic [7:0] a, input logic [31:0] d, input logic irq);
        cycle_op(1'b0, 1'b1, a, 32'h0);
        exp_q.push_back({a, irq, d});
    endtask

    // monitor / scoreboard
    always @(negedge hclk) begin
        if (rd_en) begin
            logic [40:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read addr=%h got=%h", reg_addr, ihrdata);
            end else begin
                e = exp_q.pop_front();
                if (ihrdata !== e[31:0] || hsem_irq !== e[32]) begin
                    failures++;
                    $display("FAIL read addr=%h got data=%h irq=%b expected data=%h irq=%b",
                             e[40:33], ihrdata, hsem_irq, e[31:0], e[32]);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [5:0]  ix;
        logic [7:0]  a;
        int          sel;

        hresetn  = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        reg_addr = 8'h0;
        ihwdata  = 32'h0;
        model_reset();

        // reset state, read while reset is held
        rd_k(8'h00, 32'h0, 1'b0);
        rd_k(8'h44, 32'h0, 1'b0);
        rd_k(8'h54, 32'h0, 1'b0);
        cycle_op(1'b0, 1'b0, 8'h0, 32'h0);
        hresetn = 1'b1;
        rd_k(8'h48, 32'h0, 1'b0);

        // lock, rejected foreign lock
        wr(8'h08, 32'h8000_0105);
        rd_k(8'h08, 32'h8000_0105, 1'b0);
        wr(8'h08, 32'h8000_0206);
        rd_k(8'h08, 32'h8000_0105, 1'b0);
        rd_k(8'h54, 32'h0000_0001, 1'b0);

        // idempotent relock, unmapped address
        wr(8'h08, 32'h8000_0105);
        rd_k(8'h54, 32'h0000_0001, 1'b0);
        rd_k(8'h60, 32'h0, 1'b0);
        wr(8'h60, 32'hFFFF_FFFF);
        rd_k(8'h08, 32'h8000_0105, 1'b0);
        rd_k(8'h44, 32'h0, 1'b0);

        // foreign unlock dropped without counting
        wr(8'h08, 32'h0000_0106);
        rd_k(8'h08, 32'h8000_0105, 1'b0);
        rd_k(8'h54, 32'h0000_0001, 1'b0);

        // owner unlock raises ISR and the interrupt
        wr(8'h44, 32'h0000_0004);
        wr(8'h08, 32'h0000_0105);
        rd_k(8'h08, 32'h0, 1'b1);
        rd_k(8'h48, 32'h0000_0004, 1'b1);
        rd_k(8'h4C, 32'h0000_0004, 1'b1);
        wr(8'h48, 32'h0000_0004);
        rd_k(8'h48, 32'h0, 1'b0);

        // unlock of a FREE semaphore leaves ISR alone
        wr(8'h0C, 32'h0000_0000);
        rd_k(8'h48, 32'h0, 1'b0);

        // keyed clear-all by COREID
        wr(8'h50, 32'hA5A5_0000);
        rd_k(8'h50, 32'hA5A5_0000, 1'b0);
        wr(8'h44, 32'h0);
        wr(8'h00, 32'h8000_0007);
        wr(8'h0C, 32'h8000_1107);
        wr(8'h04, 32'h8000_0002);
        wr(8'h40, 32'h1234_0007);
        rd_k(8'h00, 32'h8000_0007, 1'b0);
        rd_k(8'h48, 32'h0, 1'b0);
        wr(8'h40, 32'hA5A5_0007);
        rd_k(8'h00, 32'h0, 1'b0);
        rd_k(8'h0C, 32'h0, 1'b0);
        rd_k(8'h04, 32'h8000_0002, 1'b0);
        rd_k(8'h48, 32'h0000_0009, 1'b0);
        rd_k(8'h40, 32'h0, 1'b0);

        // a clear on a zero bit must not mask the following release
        wr(8'h48, 32'h0000_00FF);
        wr(8'h08, 32'h8000_0105);
        wr(8'h48, 32'h0000_0004);
        wr(8'h08, 32'h0000_0105);
        rd_k(8'h48, 32'h0000_0004, 1'b0);
        wr(8'h48, 32'h0000_00FF);

        // FAILCNT saturation
        wr(8'h54, 32'h0);
        wr(8'h14, 32'h8000_0101);
        for (int k = 0; k < 65534; k++) wr(8'h14, 32'h8000_0202);
        rd_k(8'h54, 32'h0000_FFFE, 1'b0);
        wr(8'h14, 32'h8000_0202);
        wr(8'h14, 32'h8000_0303);
        rd_k(8'h54, 32'h0000_FFFF, 1'b0);
        wr(8'h14, 32'h8000_0404);
        rd_k(8'h54, 32'h0000_FFFF, 1'b0);
        wr(8'h54, 32'h1234_5678);
        rd_k(8'h54, 32'h0, 1'b0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            d   = $urandom;
            d[15:8] = 8'($urandom_range(0, 1));
            d[7:0]  = 8'($urandom_range(1, 3));
            if (sel <= 4)       ix = 6'($urandom_range(0, NSEM));
            else if (sel == 5)  ix = 6'h10;
            else if (sel == 6)  ix = 6'h11;
            else if (sel == 7)  ix = 6'h12;
            else if (sel == 8)  ix = 6'($urandom_range(19, 21));
            else                ix = 6'h18;
            a = {ix, 2'b00};
            if (sel == 5 && $urandom_range(0, 1) == 1) d[31:16] = m_key;
            if ($urandom_range(0, 2) == 0) rd(a);
            else                           wr(a, d);
        end
        for (int s = 0; s < 22; s++) rd(8'(s * 4));

        // reset asserted together with a lock write
        @(posedge hclk);
        #1;
        wr_en    = 1'b1;
        rd_en    = 1'b0;
        reg_addr = 8'h00;
        ihwdata  = 32'h8000_0303;
        hresetn  = 1'b0;
        model_reset();
        cycle_op(1'b0, 1'b0, 8'h0, 32'h0);
        cycle_op(1'b0, 1'b0, 8'h0, 32'h0);
        hresetn = 1'b1;
        for (int s = 0; s < 22; s++) rd_k(8'(s * 4), 32'h0, 1'b0);
        wr(8'h00, 32'h8000_0303);
        rd_k(8'h00, 32'h8000_0303, 1'b0);
        rd(8'h00);

        cycle_op(1'b0, 1'b0, 8'h0, 32'h0);
        repeat (2) @(posedge hclk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hsem_regfile.md
HSEM_REGFILE -- requirements
Module: hsem_regfile

Interface
REQ-001 SHALL expose parameters, one per line:
  NSEM, 8, number of semaphores (1..16).
  AHB_DATA_WIDTH, 32, data bus width.
REQ-002 SHALL expose ports, one per line:
  hclk  input  1  single clock; all state updates on its rising edge.
  hresetn  input  1  reset, asynchronous, active-low.
  wr_en  input  1  write strobe from the bus interface; one write per asserted cycle.
  rd_en  input  1  read strobe from the bus interface.
  reg_addr  input  8  byte address; decode uses bits [7:2] only.
  ihwdata  input  32  write data; valid in the wr_en cycle.
  ihrdata  output  32  read data; combinational from registered state.
  hsem_irq  output  1  level interrupt.

Function
REQ-003 SHALL implement this register map; other addresses read 0 and writes are ignored:
  0x00+4n  SEM_Rn: {LOCK[31], 15'b0, PROCID[15:8], COREID[7:0]}.
  0x40  CR: clear-all, write-only, reads 0.
  0x44  IER: [NSEM-1:0] interrupt enable, RW.
  0x48  ISR: [NSEM-1:0] raw status, write-1-to-clear.
  0x4C  MISR: ISR & IER, read-only.
  0x50  KEYR: [31:16] clear key, RW; [15:0] read 0.
  0x54  FAILCNT: [15:0] rejected-lock counter, read-only; any write clears it.
REQ-004 SHALL drive ihrdata to the decoded value when rd_en=1, else 0; reads SHALL have no side effects.
REQ-005 Each semaphore SHALL be a two-state FSM, FREE/LOCKED, holding COREID and PROCID.
REQ-006 FREE + write SEM_Rn with ihwdata[31]=1: SHALL go LOCKED at that clock edge and capture ihwdata[15:0].
REQ-007 LOCKED + lock write with identical COREID/PROCID: SHALL stay LOCKED (idempotent); this is not a failure.
REQ-008 LOCKED + lock write with different IDs: SHALL keep state; FAILCNT +1.
REQ-009 LOCKED + write with ihwdata[31]=0 and matching COREID/PROCID:
  - SHALL go FREE, with IDs cleared to 0.
  - SHALL set ISR[n] at the same edge.
  - Non-matching unlock SHALL be ignored without counting.
REQ-010 FREE + unlock write: SHALL be ignored; ISR is unchanged.
REQ-011 CR write with ihwdata[31:16]==KEYR[31:16]:
  - SHALL free every LOCKED semaphore whose COREID==ihwdata[7:0], regardless of PROCID.
  - SHALL set the ISR bit of each semaphore it frees.
  - Key mismatch: no effect.
REQ-012 FAILCNT SHALL saturate at 0xFFFF and never wrap.
REQ-013 ISR write: bits written 1 clear. If a set event and a clear hit the same bit on the same edge, set SHALL win.
REQ-014 hsem_irq SHALL equal OR of (ISR & IER), driven from flops without combinational paths from inputs.
REQ-015 Write-to-read visibility: a value written at edge k SHALL be readable in any rd_en cycle after edge k (zero added latency).
REQ-016 Only one register is addressed per cycle, so at most one semaphore changes per write; CR may change many.

Reset
REQ-017 hresetn low SHALL asynchronously force:
  - all semaphores FREE, with IDs 0;
  - IER=0, ISR=0, KEYR=0, FAILCNT=0;
  - hsem_irq=0, ihrdata=0.
REQ-018 Reset asserted mid-operation SHALL discard any in-flight write. The first write honoured SHALL be one in a cycle after hresetn is sampled high.

Verification
REQ-019 Lock: write SEM_R2=0x8000_0105, read SEM_R2 -> 0x8000_0105. Write SEM_R2=0x8000_0206 -> read still 0x8000_0105, FAILCNT=1.
REQ-020 Unlock/irq: IER=0x04, SEM_R2 locked 0x0105. Write SEM_R2=0x0000_0105 -> SEM_R2 reads 0, ISR=0x04, hsem_irq=1. Write ISR=0x04 -> ISR=0, hsem_irq=0.
REQ-021 Clear-all: KEYR=0xA5A5_0000; SEM0/SEM3 locked COREID 0x07, SEM1 locked COREID 0x02.
  - CR=0x1234_0007 -> no change.
  - CR=0xA5A5_0007 -> SEM0/SEM3 FREE, SEM1 LOCKED, ISR=0x09.
REQ-022 Saturation/collision:
  - Preload FAILCNT=0xFFFE via rejected locks; two more rejected locks -> FAILCNT=0xFFFF.
  - Any FAILCNT write -> 0.
  - Same-edge ISR W1C of bit2 with unlock of SEM2 -> ISR[2]=1.
REQ-023 Reset mid-op: assert hresetn low in the same cycle as a lock write with wr_en=1 -> all registers read 0 after release, and SEM_Rn is FREE.
REQ-024 Unmapped/idempotent:
  - Read 0x60 -> 0; write 0x60 -> no state change.
  - Repeat an identical lock write -> FAILCNT unchanged.
